// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
package clk_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_t;

endpackage

// File: rtl/clk_div_chan.sv
// Single divider channel: holds its divisor and mode, counts, and drives a registered clk_out and tick.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CW      = 18,
    parameter int unsigned DEF_DIV = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          sync,
    input  logic          load,
    input  logic [CW-1:0] ld_div,
    input  logic          ld_mode,
    output logic          clk_out,
    output logic          tick
);

    logic [CW-1:0] div;
    logic [CW-1:0] cnt;
    mode_t         mode;
    logic          terminal;

    assign terminal = (cnt == div - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= CW'(DEF_DIV);
            mode    <= MODE_TOGGLE;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (load) begin
                div  <= ld_div;
                mode <= mode_t'(ld_mode);
            end
            // A restart outranks a coinciding terminal count: no tick, no toggle.
            if (load || sync) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (div == '0) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (!en) begin
                tick <= 1'b0;
                if (mode == MODE_PULSE) clk_out <= 1'b0;
            end else if (terminal) begin
                cnt     <= '0;
                tick    <= 1'b1;
                clk_out <= (mode == MODE_PULSE) ? 1'b1 : ~clk_out;
            end else begin
                cnt  <= cnt + CW'(1);
                tick <= 1'b0;
                if (mode == MODE_PULSE) clk_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: decodes configuration writes and fans reset/sync out to each channel.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned CW      = 18,
    parameter int unsigned DEF_DIV = 100000,
    localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_div,
    input  logic           wr_mode,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick
);

    logic [NCH-1:0] load;

    // Out-of-range channel indices match no channel, so such writes fall away.
    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (wr_en && (32'(wr_ch) == i)) load[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .sync    (sync),
            .load    (load[g]),
            .ld_div  (wr_div),
            .ld_mode (wr_mode),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: stimulus queues expected per-cycle outputs, a negedge monitor compares.
module tb_clk_div_multi;

    localparam int unsigned NCH = 5;
    localparam int unsigned CW  = 8;
    localparam int unsigned DEF = 6;
    localparam int unsigned CHW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           sync;
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_div;
    logic           wr_mode;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int             cyc;
        string          name;
        logic [NCH-1:0] mask;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] clk;
    } exp_t;

    exp_t q[$];

    clk_div_multi #(
        .NCH     (NCH),
        .CW      (CW),
        .DEF_DIV (DEF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_mode (wr_mode),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_tests++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc);
            end else if (((tick & e.mask) != (e.tick & e.mask)) ||
                         ((clk_out & e.mask) != (e.clk & e.mask))) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: tick=%b (exp %b) clk_out=%b (exp %b) mask=%b",
                         e.name, cyc, tick & e.mask, e.tick & e.mask,
                         clk_out & e.mask, e.clk & e.mask, e.mask);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input int c, input logic [NCH-1:0] m,
                        input logic [NCH-1:0] t, input logic [NCH-1:0] k);
        exp_t e;
        e.cyc = c; e.name = name; e.mask = m; e.tick = t; e.clk = k;
        q.push_back(e);
    endtask

    task automatic drain();
        int budget = 200;
        while (q.size() > 0 && budget > 0) begin
            step();
            budget--;
        end
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations never reached", q.size());
            $fatal(1, "scoreboard stalled");
        end
    endtask

    task automatic wr(input int ch, input int dv, input logic md);
        wr_en   = 1'b1;
        wr_ch   = CHW'(ch);
        wr_div  = CW'(dv);
        wr_mode = md;
    endtask

    initial begin
        int e0;
        logic [NCH-1:0] t;
        logic [NCH-1:0] k;

        rst = 1'b1; en = '0; sync = 1'b0;
        wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0;
        step();

        // Reset state
        e0 = cyc + 1;
        push("reset", e0, '1, '0, '0);
        step();
        rst = 1'b0; en = '1;

        // Default divisor on every channel, aligned by sync
        sync = 1'b1;
        e0 = cyc + 1;
        for (int i = 0; i <= 6; i++) begin
            t = (i == 6) ? '1 : '0;
            push("default_div", e0 + i, '1, t, t);
        end
        step();
        sync = 1'b0;
        drain();

        // ch0 div=4 TOGGLE
        wr(0, 4, 1'b0);
        e0 = cyc + 1;
        for (int i = 0; i <= 12; i++) begin
            t = (i > 0 && i % 4 == 0) ? 5'b00001 : 5'b00000;
            k = (((i / 4) % 2) == 1) ? 5'b00001 : 5'b00000;
            push("ch0_div4_toggle", e0 + i, 5'b00001, t, k);
        end
        step();
        wr_en = 1'b0;
        drain();

        // ch1 div=3 PULSE
        wr(1, 3, 1'b1);
        e0 = cyc + 1;
        for (int i = 0; i <= 9; i++) begin
            t = (i > 0 && i % 3 == 0) ? 5'b00010 : 5'b00000;
            push("ch1_div3_pulse", e0 + i, 5'b00010, t, t);
        end
        step();
        wr_en = 1'b0;
        drain();

        // ch0 div=5 with en[0] dropped for edges E3..E9
        wr(0, 5, 1'b0);
        e0 = cyc + 1;
        for (int i = 0; i <= 17; i++) begin
            t = (i == 12 || i == 17) ? 5'b00001 : 5'b00000;
            k = (i >= 12 && i <= 16) ? 5'b00001 : 5'b00000;
            push("ch0_en_freeze", e0 + i, 5'b00001, t, k);
        end
        step();
        wr_en = 1'b0;
        step();
        step();
        en[0] = 1'b0;
        repeat (7) step();
        en[0] = 1'b1;
        drain();

        // ch2: write on terminal count, then an out-of-range write
        wr(2, 3, 1'b0);
        e0 = cyc + 1;
        push("ch2_wr", e0 + 0, 5'b00100, 5'b00000, 5'b00000);
        push("ch2_wr", e0 + 3, 5'b00100, 5'b00100, 5'b00100);
        push("ch2_wr", e0 + 5, 5'b00100, 5'b00000, 5'b00100);
        push("ch2_wr_on_tc", e0 + 6, 5'b00100, 5'b00000, 5'b00000);
        push("ch2_wr_on_tc", e0 + 9, 5'b00100, 5'b00000, 5'b00000);
        push("ch2_newdiv", e0 + 10, 5'b00100, 5'b00100, 5'b00100);
        push("ch2_newdiv", e0 + 13, 5'b00100, 5'b00000, 5'b00100);
        push("ch2_bad_wr", e0 + 14, 5'b00100, 5'b00100, 5'b00000);
        push("ch2_bad_wr", e0 + 15, 5'b00100, 5'b00000, 5'b00000);
        push("ch2_bad_wr", e0 + 18, 5'b00100, 5'b00100, 5'b00100);
        step();
        wr_en = 1'b0;
        repeat (5) step();
        wr(2, 4, 1'b0);
        step();
        wr_en = 1'b0;
        repeat (5) step();
        wr(5, 1, 1'b1);
        step();
        wr_en = 1'b0;
        drain();

        // ch0 div=2 TOGGLE, then sync together with a ch1 div=3 PULSE write
        wr(0, 2, 1'b0);
        step();
        wr(1, 3, 1'b1);
        sync = 1'b1;
        e0 = cyc + 1;
        for (int i = 0; i <= 6; i++) begin
            t = '0; k = '0;
            if (i > 0 && i % 2 == 0) t[0] = 1'b1;
            if (((i / 2) % 2) == 1) k[0] = 1'b1;
            if (i > 0 && i % 3 == 0) begin t[1] = 1'b1; k[1] = 1'b1; end
            push("sync_align", e0 + i, 5'b00011, t, k);
        end
        step();
        wr_en = 1'b0;
        sync = 1'b0;
        drain();

        // ch3 div=0 disables the channel
        wr(3, 0, 1'b0);
        e0 = cyc + 1;
        for (int i = 0; i <= 5; i++) push("ch3_div0", e0 + i, 5'b01000, '0, '0);
        step();
        wr_en = 1'b0;
        drain();

        // ch3 div=1 TOGGLE: tick every cycle, clk/2
        wr(3, 1, 1'b0);
        e0 = cyc + 1;
        for (int i = 0; i <= 6; i++) begin
            t = (i > 0) ? 5'b01000 : 5'b00000;
            k = (i % 2 == 1) ? 5'b01000 : 5'b00000;
            push("ch3_div1", e0 + i, 5'b01000, t, k);
        end
        step();
        wr_en = 1'b0;
        drain();

        // Reset mid-run dominates a concurrent write and sync
        rst = 1'b1;
        sync = 1'b1;
        wr(3, 0, 1'b1);
        e0 = cyc + 1;
        push("rst_midrun", e0, '1, '0, '0);
        step();
        rst = 1'b0;
        wr_en = 1'b0;
        e0 = cyc + 1;
        for (int i = 0; i <= 6; i++) begin
            t = (i == 6) ? '1 : '0;
            push("rst_def_div", e0 + i, '1, t, t);
        end
        step();
        sync = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
